// File: rtl/des_key_sched_pkg.sv
// des_pkg: shared constants, permutation tables and schedule helpers for the
// DES round-key scheduler.
// Ports: none (package). Table entries use DES numbering: bit 1 is the MSB.
package des_pkg;

  localparam int KEY_W = 64;
  localparam int CD_W  = 28;
  localparam int RK_W  = 48;

  localparam logic [15:0] DES_SHIFT_DEFAULT = 16'h7EFC;

  // Permuted choice 1: 64-bit key -> 56-bit C||D (parity bits dropped)
  localparam int PC1_TBL [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // Permuted choice 2: 56-bit C||D -> 48-bit round key
  localparam int PC2_TBL [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Rotate amount for round r (1-based). Out-of-range rounds only occur on the
  // final advance, whose result is never emitted, so any value is harmless.
  function automatic int des_shift_amt(logic [15:0] sched, int round);
    if (round < 1 || round > 16) return 1;
    return sched[4'(round - 1)] ? 2 : 1;
  endfunction

  // Total rotation from C0/D0 to CN/DN, folded mod 28.
  function automatic int des_tot(logic [15:0] sched, int num_rounds);
    int sum;
    sum = 0;
    for (int r = 1; r <= num_rounds; r++) sum += des_shift_amt(sched, r);
    return sum % CD_W;
  endfunction

  // 28-bit rotate left by amt (0..27 after folding).
  function automatic logic [CD_W-1:0] des_rotl(logic [CD_W-1:0] x, int amt);
    logic [2*CD_W-1:0] dbl;
    dbl = {x, x} << (amt % CD_W);
    return dbl[2*CD_W-1:CD_W];
  endfunction

endpackage

// File: rtl/des_key_sched_pc2.sv
// des_pc2: combinational PC-2 permutation, 56-bit C||D in, 48-bit subkey out.
// Ports: cd (C in [55:28], D in [27:0]), rk (round key, DES bit 1 = MSB).
// Latency 0; no flow control.
module des_pc2
  import des_pkg::*;
(
  input  logic [2*CD_W-1:0] cd,
  output logic [RK_W-1:0]   rk
);

  always_comb begin
    rk = '0;
    for (int i = 0; i < RK_W; i++) begin
      rk[6'(RK_W - 1 - i)] = cd[6'(2*CD_W - PC2_TBL[i])];
    end
  end

endmodule

// File: rtl/des_key_sched.sv
// des_key_sched: latches a DES key on start and emits NUM_ROUNDS registered
// subkeys over a valid/ready handshake, in encrypt (K1..KN) or decrypt (KN..K1) order.
// Ports: clk, rst_n (async low), start/decrypt/key in; rk_ready in; rk_valid,
// round_key, round_idx, rk_last, busy, done out. First key 1 cycle after start;
// rk_ready low freezes all outputs.
module des_key_sched
  import des_pkg::*;
#(
  parameter int          NUM_ROUNDS  = 16,
  parameter logic [15:0] SHIFT_SCHED = DES_SHIFT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             decrypt,
  input  logic [KEY_W-1:0] key,
  input  logic             rk_ready,
  output logic             rk_valid,
  output logic [RK_W-1:0]  round_key,
  output logic [4:0]       round_idx,
  output logic             rk_last,
  output logic             busy,
  output logic             done
);

  localparam int         TOT      = des_tot(SHIFT_SCHED, NUM_ROUNDS);
  localparam logic [4:0] LAST_IDX = 5'(NUM_ROUNDS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CD_W-1:0]   c_q, c_d, d_q, d_d;
  logic [RK_W-1:0]   round_key_q, round_key_d;
  logic [4:0]        round_idx_q, round_idx_d;
  logic              dec_q, dec_d;
  logic              done_q, done_d;

  logic [2*CD_W-1:0] pc1_out;
  logic [RK_W-1:0]   pc2_out;
  logic              launch, hs, last_hs;
  int                adv;

  // Parity bits are deliberately dropped by PC-1.
  logic unused_parity;
  assign unused_parity = ^{key[56], key[48], key[40], key[32],
                           key[24], key[16], key[8],  key[0]};

  always_comb begin
    pc1_out = '0;
    for (int i = 0; i < 2*CD_W; i++) begin
      pc1_out[6'(2*CD_W - 1 - i)] = key[6'(KEY_W - PC1_TBL[i])];
    end
  end

  assign launch  = (state_q == S_IDLE) && start;
  assign hs      = (state_q == S_RUN) && rk_ready;
  assign last_hs = hs && (round_idx_q == LAST_IDX);

  // C/D always holds the state that produced the subkey currently on round_key.
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    d_d         = d_q;
    dec_d       = dec_q;
    round_idx_d = round_idx_q;
    done_d      = last_hs;
    adv         = 0;
    if (launch) begin
      state_d     = S_RUN;
      dec_d       = decrypt;
      round_idx_d = '0;
      adv         = decrypt ? TOT : des_shift_amt(SHIFT_SCHED, 1);
      c_d         = des_rotl(pc1_out[2*CD_W-1:CD_W], adv);
      d_d         = des_rotl(pc1_out[CD_W-1:0], adv);
    end else if (hs) begin
      // Decrypt walks backwards, so it undoes the rotate of the round just emitted.
      if (dec_q) adv = CD_W - des_shift_amt(SHIFT_SCHED, NUM_ROUNDS - int'(round_idx_q));
      else       adv = des_shift_amt(SHIFT_SCHED, int'(round_idx_q) + 2);
      c_d = des_rotl(c_q, adv);
      d_d = des_rotl(d_q, adv);
      if (last_hs) begin
        state_d     = S_IDLE;
        round_idx_d = '0;
      end else begin
        round_idx_d = round_idx_q + 5'd1;
      end
    end
  end

  des_pc2 u_pc2 (
    .cd (({c_d, d_d})),
    .rk (pc2_out)
  );

  always_comb begin
    round_key_d = round_key_q;
    if (launch || hs) round_key_d = pc2_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      c_q         <= '0;
      d_q         <= '0;
      dec_q       <= 1'b0;
      round_idx_q <= '0;
      round_key_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      d_q         <= d_d;
      dec_q       <= dec_d;
      round_idx_q <= round_idx_d;
      round_key_q <= round_key_d;
      done_q      <= done_d;
    end
  end

  assign rk_valid  = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN);
  assign rk_last   = rk_valid && (round_idx_q == LAST_IDX);
  assign round_key = round_key_q;
  assign round_idx = round_idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_des_key_sched.sv
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst_n, decrypt, rk_ready;
  logic [63:0] key;
  logic        start, start1, start12;

  logic        v16, last16, busy16, done16;
  logic [47:0] k16;
  logic [4:0]  i16;
  logic        v1, last1, busy1, done1;
  logic [47:0] k1;
  logic [4:0]  i1;
  logic        v12, last12, busy12, done12;
  logic [47:0] k12;
  logic [4:0]  i12;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0123456789ABCDEF;

  // Reference subkeys K1..K16 for KEY_A (standard DES worked example).
  logic [47:0] kref [0:15] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  always #5 clk = ~clk;

  des_key_sched #(.NUM_ROUNDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .key(key),
    .rk_ready(rk_ready), .rk_valid(v16), .round_key(k16), .round_idx(i16),
    .rk_last(last16), .busy(busy16), .done(done16)
  );

  des_key_sched #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .decrypt(decrypt), .key(key),
    .rk_ready(rk_ready), .rk_valid(v1), .round_key(k1), .round_idx(i1),
    .rk_last(last1), .busy(busy1), .done(done1)
  );

  des_key_sched #(.NUM_ROUNDS(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start12), .decrypt(decrypt), .key(key),
    .rk_ready(rk_ready), .rk_valid(v12), .round_key(k12), .round_idx(i12),
    .rk_last(last12), .busy(busy12), .done(done12)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one full 16-round schedule with rk_ready high, checking every key.
  task automatic run16(input logic dec, input string nm);
    decrypt = dec; start = 1'b1;
    step();
    start = 1'b0;
    chk({nm, "_busy"}, 64'(busy16), 64'd1);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("%s_key[%0d]", nm, j), 64'(k16), 64'(dec ? kref[15-j] : kref[j]));
      chk($sformatf("%s_idx[%0d]", nm, j), 64'(i16), 64'(j));
      chk($sformatf("%s_last[%0d]", nm, j), 64'({v16, last16}), 64'({1'b1, j == 15}));
      step();
    end
    chk({nm, "_done"}, 64'({done16, busy16, v16}), 64'b100);
  endtask

  initial begin
    int e;
    int cyc;
    logic hsn;
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; start12 = 1'b0;
    decrypt = 1'b0; rk_ready = 1'b0; key = KEY_A;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", 64'({v16, last16, busy16, done16}), 64'd0);
    chk("rst_key", 64'(k16), 64'd0);
    chk("rst_idx", 64'(i16), 64'd0);
    rst_n = 1'b1;
    step();

    // Encrypt and decrypt with rk_ready held high
    rk_ready = 1'b1;
    run16(1'b0, "enc");
    step();
    chk("done_one_cycle", 64'(done16), 64'd0);
    run16(1'b1, "dec");
    step();

    // Random stalls: index must only advance on a handshake
    decrypt = 1'b0; start = 1'b1; rk_ready = 1'b0;
    step();
    start = 1'b0;
    e = 0; cyc = 0;
    while (e < 16 && cyc < 400) begin
      chk($sformatf("stall_kv[c%0d]", cyc), {8'(i16), 7'(v16), 1'(last16), k16},
          {8'(e), 7'd1, 1'(e == 15), kref[e]});
      rk_ready = 1'($urandom_range(0, 1));
      hsn = v16 && rk_ready;
      step();
      if (hsn) e++;
      cyc++;
    end
    chk("stall_count", 64'(e), 64'd16);
    chk("stall_done", 64'({done16, busy16}), 64'b10);
    rk_ready = 1'b1;
    step();

    // start while busy is ignored, and key/decrypt are not re-sampled
    decrypt = 1'b0; start = 1'b1;
    step();
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("ign_key[%0d]", j), 64'({i16, k16}), 64'({5'(j), kref[j]}));
      if (j == 5) begin start = 1'b1; key = KEY_B; decrypt = 1'b1; end
      else        begin start = 1'b0; key = KEY_A; decrypt = 1'b0; end
      step();
    end
    chk("ign_done", 64'(done16), 64'd1);
    // start in the done cycle launches immediately
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_first", 64'({v16, i16, k16}), 64'({1'b1, 5'd0, kref[0]}));
    repeat (7) step();
    chk("pre_rst_idx", 64'({i16, k16}), 64'({5'd7, kref[7]}));

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", 64'({v16, last16, busy16, done16}), 64'd0);
    chk("arst_data", 64'({i16, k16}), 64'd0);
    step();
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("post_rst_idle[%0d]", j), 64'({done16, busy16, v16}), 64'd0);
      step();
    end

    // Short schedules: NUM_ROUNDS = 1 and 12, encrypt then decrypt
    for (int d = 0; d < 2; d++) begin
      decrypt = 1'(d); start1 = 1'b1; start12 = 1'b1;
      step();
      start1 = 1'b0; start12 = 1'b0;
      for (int j = 0; j < 12; j++) begin
        chk($sformatf("n12_d%0d_key[%0d]", d, j), 64'({i12, k12}),
            64'({5'(j), (d == 1) ? kref[11-j] : kref[j]}));
        chk($sformatf("n12_d%0d_last[%0d]", d, j), 64'({v12, last12}), 64'({1'b1, j == 11}));
        if (j == 0)
          chk($sformatf("n1_d%0d_first", d), 64'({v1, last1, i1, k1}),
              64'({1'b1, 1'b1, 5'd0, kref[0]}));
        if (j == 1)
          chk($sformatf("n1_d%0d_done", d), 64'({done1, busy1, v1}), 64'b100);
        step();
      end
      chk($sformatf("n12_d%0d_done", d), 64'({done12, busy12}), 64'b10);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_key_sched.md
# des_key_sched

Parametrised DES round-key scheduler that supersedes the combinational keygen plus free-running counter pair. On a start pulse it latches a 64-bit key and emits NUM_ROUNDS 48-bit subkeys, one per accepted valid/ready handshake, in encrypt order (K1 first) or decrypt order (last key first). It sits between the key register and the DES round datapath, which consumes one subkey per round and may stall.

## Interface
- NUM_ROUNDS, 16, number of subkeys per schedule; legal range 1..16.
- SHIFT_SCHED, 16'h7EFC, per-round rotate amount; bit r-1 = 1 means round r rotates by 2, otherwise by 1. The default is the standard DES schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; accepted only while busy=0.
- decrypt  in  1  order select, sampled with start; 0 = K1..KN, 1 = KN..K1.
- key  in  64  DES key (bit 63 = DES bit 1), sampled with start. Parity bits are ignored.
- rk_ready  in  1  consumer accepts round_key this cycle.
- rk_valid  out  1  round_key / round_idx valid.
- round_key  out  48  current subkey, PC-2 output.
- round_idx  out  5  emission index 0..NUM_ROUNDS-1.
- rk_last  out  1  high with the final subkey of the schedule.
- busy  out  1  schedule in progress.
- done  out  1  one-cycle pulse after the final handshake.

## Operation
- FSM states:
  - IDLE: start moves to RUN.
  - RUN: a handshake on the final index moves to IDLE.
- Start in IDLE: apply PC-1 to key and load 28-bit C/D registers.
  - Encrypt: load C/D rotated left by SHIFT_SCHED[0], giving C1/D1.
  - Decrypt: load C/D rotated left by TOT, giving CN/DN. TOT is the sum of the rotates for rounds 1..NUM_ROUNDS, mod 28, computed at elaboration. TOT = 0 for NUM_ROUNDS=16.
- round_key is registered as PC-2(C,D) and is updated on every handshake (rk_valid & rk_ready).
- On each handshake at index j, advance C/D:
  - Encrypt: rotate left by the rotate amount of round j+2.
  - Decrypt: rotate right by the rotate amount of round NUM_ROUNDS-j.
- rk_last = rk_valid & (round_idx == NUM_ROUNDS-1).
- All rotates are mod 28 on C and D independently. round_idx never exceeds NUM_ROUNDS-1.
- start while busy=1 is ignored. key and decrypt are not re-sampled mid-schedule.
- Reset values: rk_valid=0, round_key=0, round_idx=0, rk_last=0, busy=0, done=0, FSM=IDLE, C/D=0.
- Reset asserted mid-schedule aborts immediately. No done pulse is produced, and the next schedule needs a fresh start.

## Timing
- start sampled at edge t gives busy=1 and rk_valid=1 with index 0 from t+1. First-key latency is 1 cycle.
- With rk_ready held high, one subkey per cycle; N subkeys occupy cycles t+1..t+N.
- rk_ready low holds round_key, round_idx and rk_last stable. No data is lost or skipped.
- A final handshake at edge u gives, at u+1: rk_valid=0, busy=0, done=1 for one cycle.
- start is accepted at the u+1 edge itself (busy=0 there). Back-to-back schedules therefore have a one-cycle bubble.
- NUM_ROUNDS=1: rk_last and rk_valid are both asserted at t+1.

## Structure
- Package des_pkg:
  - PC1 table (56 entries) and PC2 table (48 entries).
  - DES_SHIFT_DEFAULT = 16'h7EFC.
  - Width constants KEY_W=64, CD_W=28, RK_W=48.
  - A function computing TOT from SHIFT_SCHED and NUM_ROUNDS.
- Sub-module des_pc2: purely combinational 56→48 permutation, instanced once. PC-1 stays inline.
- Expected RTL size: 150–250 lines.

## Test plan
- Encrypt, key 64'h133457799BBCDFF1, rk_ready=1. Required:
  - idx0 = 48'h1B02EFFC7072.
  - idx1 = 48'h79AED9DBC9E5.
  - idx15 = 48'hCB3D8B0E17F5, with rk_last=1.
  - done pulses at t+17.
- Decrypt, same key: the emitted sequence is exactly the encrypt sequence reversed; idx0 = 48'hCB3D8B0E17F5.
- Random rk_ready toggling (50%): outputs stay stable while stalled, the full 16-key sequence matches the reference, and there are no duplicates or skips.
- start pulsed at idx 5 with a different key: ignored, and the original sequence completes. A start in the done cycle launches a new schedule.
- rst_n dropped at idx 7 (async, mid-cycle): all outputs are 0 immediately; after release, no done appears until a new start.
- NUM_ROUNDS=1 and NUM_ROUNDS=12 builds:
  - Encrypt keys equal K1..KN of the 16-round model.
  - Decrypt yields KN..K1.
  - rk_last lands on the correct index.
